// File: rtl/mash_quantizer_param_if.sv
// mash_quantizer_param_if: sample-in / code-out bundle between the MASH accumulator stages and the DAC mux.
interface mash_quantizer_param_if #(
    parameter int IN_W = 16,
    parameter int OUT_W = 3
);
    localparam int E = IN_W - OUT_W;
    logic                    in_valid;
    logic [1:0]              mode;
    logic signed [IN_W-1:0]  x_in;
    logic signed [OUT_W-1:0] y_out;
    logic signed [E:0]       e_out;
    logic                    out_valid;
    logic                    sat_flag;
    logic [7:0]              sat_cnt;
    modport master (
        output in_valid, mode, x_in,
        input  y_out, e_out, out_valid, sat_flag, sat_cnt
    );
    modport slave (
        input  in_valid, mode, x_in,
        output y_out, e_out, out_valid, sat_flag, sat_cnt
    );
endinterface

// File: rtl/mash_quantizer_param.sv
// mash_quantizer_param: single-stage signed quantiser (truncate/round/error-feedback/dither) with clamp and saturation count.
module mash_quantizer_param #(
    parameter int IN_W = 16,
    parameter int OUT_W = 3
) (
    input logic clck,
    input logic rst,
    mash_quantizer_param_if.slave bus
);
    localparam int E = IN_W - OUT_W;
    localparam int V = IN_W + 2;
    localparam logic signed [V-1:0] QMAX = V'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [V-1:0] QMIN = V'(-(1 << (OUT_W - 1)));
    localparam logic signed [V-1:0] EMAX = V'((1 << E) - 1);
    localparam logic signed [V-1:0] EMIN = V'(-(1 << E));
    localparam logic signed [V-1:0] HALF = V'(1 << (E - 1));

    logic [1:0]              mode_q;
    logic signed [E:0]       e_prev;
    logic [15:0]             lfsr;
    logic signed [E:0]       fb;
    logic signed [V-1:0]     x_ext, add, v, q, y_ext, e_full;
    logic signed [OUT_W-1:0] y;
    logic signed [E:0]       e;
    logic                    sat;

    always_comb begin
        fb = (bus.mode != mode_q) ? '0 : e_prev;
        x_ext = {{2{bus.x_in[IN_W-1]}}, bus.x_in};
        add = bus.mode == 2'b00 ? '0 :
              bus.mode == 2'b01 ? HALF :
              bus.mode == 2'b10 ? {{(V-E-1){fb[E]}}, fb} :
                                  {{(V-E){1'b0}}, lfsr[E-1:0]};
        v = x_ext + add;
        q = v >>> E;
        sat = (q > QMAX) || (q < QMIN);
        y = q > QMAX ? QMAX[OUT_W-1:0] : q < QMIN ? QMIN[OUT_W-1:0] : q[OUT_W-1:0];
        y_ext = {{(V-OUT_W){y[OUT_W-1]}}, y};
        e_full = v - (y_ext <<< E);
        e = e_full > EMAX ? EMAX[E:0] : e_full < EMIN ? EMIN[E:0] : e_full[E:0];
    end

    always_ff @(posedge clck) begin
        if (rst) begin
            bus.y_out     <= '0;
            bus.e_out     <= '0;
            bus.out_valid <= 1'b0;
            bus.sat_flag  <= 1'b0;
            bus.sat_cnt   <= '0;
            e_prev        <= '0;
            mode_q        <= '0;
            lfsr          <= 16'hACE1;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.y_out    <= y;
                bus.e_out    <= e;
                bus.sat_flag <= sat;
                mode_q       <= bus.mode;
                // A mode change discards stale feedback, but a feedback sample always captures its own error
                e_prev       <= bus.mode == 2'b10 ? e : (bus.mode != mode_q ? '0 : e_prev);
                if (bus.mode == 2'b11)
                    lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
                if (sat && bus.sat_cnt != 8'hFF)
                    bus.sat_cnt <= bus.sat_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_mash_quantizer_param.sv
// tb_mash_quantizer_param: scoreboard bench with an arithmetic reference model of the quantiser.
module tb_mash_quantizer_param;
    localparam int IN_W = 16;
    localparam int OUT_W = 3;
    localparam int E = IN_W - OUT_W;

    typedef struct {
        int acc;
        int y;
        int e;
        int sat;
        int cnt;
    } exp_t;

    logic clck = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    int m_eprev, m_modeq, m_lfsr, m_cnt;
    int last_y, last_e, last_sat, last_cnt;

    mash_quantizer_param_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();
    mash_quantizer_param #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (.clck(clck), .rst(rst), .bus(bus));

    always #5 clck = ~clck;
    always @(posedge clck) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int fdiv(input int a, input int d);
        return (a >= 0) ? a / d : -((-a + d - 1) / d);
    endfunction

    function automatic int clampi(input int a, input int lo, input int hi);
        return a > hi ? hi : (a < lo ? lo : a);
    endfunction

    task automatic model_reset();
        m_eprev = 0; m_modeq = 0; m_lfsr = 16'hACE1; m_cnt = 0;
        last_y = 0; last_e = 0; last_sat = 0; last_cnt = 0;
    endtask

    task automatic send(input int m, input int x);
        exp_t t;
        int xs, ep, a, v, qv, y, e, s, nb;
        @(posedge clck); #1;
        bus.in_valid = 1'b1;
        bus.mode = 2'(m);
        bus.x_in = 16'(x);
        xs = int'($signed(16'(x)));
        ep = (m != m_modeq) ? 0 : m_eprev;
        a = (m == 0) ? 0 : (m == 1) ? (1 << (E - 1)) : (m == 2) ? ep : (m_lfsr % (1 << E));
        v = xs + a;
        qv = fdiv(v, 1 << E);
        y = clampi(qv, -(1 << (OUT_W - 1)), (1 << (OUT_W - 1)) - 1);
        s = (y != qv) ? 1 : 0;
        e = clampi(v - y * (1 << E), -(1 << E), (1 << E) - 1);
        if (m == 2) m_eprev = e;
        else if (m != m_modeq) m_eprev = 0;
        m_modeq = m;
        if (m == 3) begin
            nb = ((m_lfsr >> 15) ^ (m_lfsr >> 13) ^ (m_lfsr >> 12) ^ (m_lfsr >> 10)) & 1;
            m_lfsr = ((m_lfsr << 1) | nb) & 16'hFFFF;
        end
        if (s == 1 && m_cnt < 255) m_cnt++;
        t.acc = cyc + 1; t.y = y; t.e = e; t.sat = s; t.cnt = m_cnt;
        sb.push_back(t);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clck); #1;
            bus.in_valid = 1'b0;
            bus.x_in = 16'($urandom);
            bus.mode = 2'($urandom);
        end
    endtask

    task automatic drain();
        int n = 0;
        idle(1);
        while (sb.size() != 0 && n < 20) begin
            @(posedge clck);
            n++;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic do_reset(input bit with_valid);
        drain();
        @(posedge clck); #1;
        rst = 1'b1;
        bus.in_valid = with_valid;
        bus.mode = 2'b10;
        bus.x_in = 16'sd3000;
        model_reset();
        @(posedge clck); #1;
        bus.in_valid = 1'b0;
        @(negedge clck);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_y", int'(bus.y_out), 0);
        chk("rst_e", int'(bus.e_out), 0);
        chk("rst_sat_flag", int'(bus.sat_flag), 0);
        chk("rst_sat_cnt", int'(bus.sat_cnt), 0);
        @(posedge clck); #1;
        rst = 1'b0;
    endtask

    always @(negedge clck) begin
        if (!rst) begin
            if (bus.out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", 1, 0);
                end else begin
                    exp_t t;
                    t = sb.pop_front();
                    chk("latency_cycle", cyc, t.acc);
                    chk("y_out", int'(bus.y_out), t.y);
                    chk("e_out", int'(bus.e_out), t.e);
                    chk("sat_flag", int'(bus.sat_flag), t.sat);
                    chk("sat_cnt", int'(bus.sat_cnt), t.cnt);
                    last_y = t.y; last_e = t.e; last_sat = t.sat; last_cnt = t.cnt;
                end
            end else begin
                if (sb.size() != 0 && sb[0].acc <= cyc) chk("missing_out_valid", 0, 1);
                chk("hold_y", int'(bus.y_out), last_y);
                chk("hold_e", int'(bus.e_out), last_e);
                chk("hold_sat_flag", int'(bus.sat_flag), last_sat);
                chk("hold_sat_cnt", int'(bus.sat_cnt), last_cnt);
            end
        end
    end

    initial begin
        int m, x, k;
        bus.in_valid = 1'b0;
        bus.mode = 2'b00;
        bus.x_in = '0;
        model_reset();
        do_reset(1'b0);
        // Truncate, isolated strobes
        send(0, 3); idle(1);
        send(0, 8192); idle(1);
        send(0, -1); idle(1);
        send(0, 16'h7FFF); idle(1);
        // Round-half-up
        send(1, 4096); idle(1);
        send(1, 4095); idle(1);
        send(1, 16'h7FFF); idle(1);
        // Error feedback, back-to-back
        for (int i = 0; i < 4; i++) send(2, 3000);
        idle(2);
        // Dither straight after reset
        do_reset(1'b0);
        send(3, 0);
        send(3, 0);
        idle(2);
        // Mode switch clears feedback
        for (int i = 0; i < 3; i++) send(2, 3000);
        send(0, 3000);
        send(2, 3000);
        send(2, 3000);
        // Reset with a sample in flight
        do_reset(1'b1);
        // Saturation counter sticks at 255
        for (int i = 0; i < 300; i++) send(1, 16'h7FFF);
        idle(2);
        // Randomised traffic
        m = 0;
        for (int i = 0; i < 3000; i++) begin
            if (i % 1000 == 999) do_reset($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 3) == 0) m = $urandom_range(0, 3);
            k = $urandom_range(0, 7);
            x = (k == 0) ? 16'h7FFF : (k == 1) ? 16'h8000 : int'($urandom_range(0, 65535));
            if ($urandom_range(0, 4) == 0) idle(1);
            else send(m, x);
        end
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
